// File: rtl/sprite_compositor.sv
// Sprite overlay for the VGA pixel stream: one rectangular sprite from a sync ROM
// over a background pixel, with key-colour transparency and tear-free position updates.
module sprite_compositor #(
  parameter int          H_START = 48,
  parameter int          V_START = 33,
  parameter int          H_DISP  = 640,
  parameter int          V_DISP  = 480,
  parameter int          SPR_W   = 32,
  parameter int          SPR_H   = 32,
  parameter logic [23:0] KEY     = 24'hFF00FF,
  parameter int          AW      = $clog2(SPR_W * SPR_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_pos,
  input  logic [9:0]    v_pos,
  input  logic [23:0]   bg_rgb,
  input  logic          spr_en,
  input  logic          pos_valid,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  output logic          pos_ready,
  output logic [AW-1:0] spr_addr,
  input  logic [23:0]   spr_rgb,
  output logic [7:0]    R_out,
  output logic [7:0]    G_out,
  output logic [7:0]    B_out,
  output logic          frame_tick
);

  localparam logic [10:0]   H_LO     = 11'(H_START);
  localparam logic [10:0]   H_HI     = 11'(H_START + H_DISP);
  localparam logic [10:0]   V_LO     = 11'(V_START);
  localparam logic [10:0]   V_HI     = 11'(V_START + V_DISP);
  localparam logic [10:0]   SPR_W_11 = 11'(SPR_W);
  localparam logic [10:0]   SPR_H_11 = 11'(SPR_H);
  localparam logic [AW-1:0] SPR_W_A  = AW'(SPR_W);

  // Handshake: a position transfers on any rising clk edge where pos_valid and
  // pos_ready are both high; the source must hold pos_valid/pos_x/pos_y until then.

  // Committed (active) sprite state and the single-entry pending slot
  logic [9:0]  ax, ay;
  logic        en_a;
  logic        pending;
  logic [9:0]  pend_x, pend_y;

  // Pipeline registers
  logic        hit_d, active_d;
  logic [23:0] rgb_q;

  // Stage 0 combinational terms
  logic [10:0]   x, y;
  logic [10:0]   ax_end, ay_end;
  logic [10:0]   dx, dy;
  logic          active, in_x, in_y, hit;
  logic [AW-1:0] addr_calc;
  logic          commit, accept;

  // Stage 1 combinational terms
  logic          spr_show;
  logic [23:0]   pix;

  assign x = {1'b0, h_pos} - H_LO;
  assign y = {1'b0, v_pos} - V_LO;

  assign active = ({1'b0, h_pos} >= H_LO) && ({1'b0, h_pos} < H_HI) &&
                  ({1'b0, v_pos} >= V_LO) && ({1'b0, v_pos} < V_HI);

  // 11-bit end coordinates: a sprite near the right/bottom edge clips instead of wrapping
  assign ax_end = {1'b0, ax} + SPR_W_11;
  assign ay_end = {1'b0, ay} + SPR_H_11;

  assign in_x = (x >= {1'b0, ax}) && (x < ax_end);
  assign in_y = (y >= {1'b0, ay}) && (y < ay_end);
  assign hit  = active && en_a && in_x && in_y;

  assign dx        = x - {1'b0, ax};
  assign dy        = y - {1'b0, ay};
  assign addr_calc = AW'(dy) * SPR_W_A + AW'(dx);

  assign commit    = (h_pos == 10'd0) && (v_pos == 10'd0);
  assign pos_ready = ~pending & ~rst;
  assign accept    = pos_valid & pos_ready;

  assign spr_show = hit_d && (spr_rgb != KEY);
  assign pix      = !active_d ? 24'h000000 : (spr_show ? spr_rgb : bg_rgb);

  always_ff @(posedge clk) begin
    if (rst) begin
      ax         <= '0;
      ay         <= '0;
      en_a       <= 1'b0;
      pending    <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      hit_d      <= 1'b0;
      active_d   <= 1'b0;
      spr_addr   <= '0;
      rgb_q      <= '0;
      frame_tick <= 1'b0;
    end else begin
      hit_d      <= hit;
      active_d   <= active;
      rgb_q      <= pix;
      frame_tick <= commit;
      if (hit) begin
        spr_addr <= addr_calc;
      end
      // Commit and accept never coincide: accept needs pending empty, and commit
      // only moves data when pending is full, so an offer on the commit pixel waits a frame.
      if (commit) begin
        en_a <= spr_en;
        if (pending) begin
          ax      <= pend_x;
          ay      <= pend_y;
          pending <= 1'b0;
        end
      end
      if (accept) begin
        pending <= 1'b1;
        pend_x  <= pos_x;
        pend_y  <= pos_y;
      end
    end
  end

  assign R_out = rgb_q[23:16];
  assign G_out = rgb_q[15:8];
  assign B_out = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: scan pixels, position handshake,
// frame commit, key transparency, edge clipping and mid-frame reset.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_pos, v_pos;
  logic [23:0] bg_rgb;
  logic        spr_en;
  logic        pos_valid;
  logic [9:0]  pos_x, pos_y;
  logic        pos_ready;
  logic [9:0]  spr_addr;
  logic [23:0] spr_rgb;
  logic [7:0]  R_out, G_out, B_out;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  logic [23:0] rom_mem [1024];
  logic [23:0] bg_q;
  logic [23:0] rgb;

  always #5 clk = ~clk;

  // ROM model: the registered spr_addr acts as the ROM's address register
  assign spr_rgb = rom_mem[spr_addr];
  assign rgb     = {R_out, G_out, B_out};

  sprite_compositor dut (
    .clk        (clk),
    .rst        (rst),
    .h_pos      (h_pos),
    .v_pos      (v_pos),
    .bg_rgb     (bg_rgb),
    .spr_en     (spr_en),
    .pos_valid  (pos_valid),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_ready  (pos_ready),
    .spr_addr   (spr_addr),
    .spr_rgb    (spr_rgb),
    .R_out      (R_out),
    .G_out      (G_out),
    .B_out      (B_out),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one scan position; its background is presented one cycle later.
  task automatic step(input int h, input int v, input logic [23:0] bg);
    h_pos  = 10'(h);
    v_pos  = 10'(v);
    bg_rgb = bg_q;
    bg_q   = bg;
    @(negedge clk);
  endtask

  // One pixel followed by a blank filler; the pixel's output is visible on return.
  task automatic pix(input int h, input int v, input logic [23:0] bg);
    step(h, v, bg);
    step(1, 1, 24'h000000);
  endtask

  task automatic vis(input int x, input int y, input logic [23:0] bg);
    pix(x + 48, y + 33, bg);
  endtask

  task automatic offer(input int x, input int y);
    pos_x     = 10'(x);
    pos_y     = 10'(y);
    pos_valid = 1'b1;
    step(1, 1, 24'h000000);
    pos_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h_pos = '0; v_pos = '0; bg_rgb = '0; bg_q = '0;
    spr_en = 1'b0; pos_valid = 1'b0; pos_x = '0; pos_y = '0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 24'hAABBCC;
    rom_mem[1023] = 24'h010203;
    rom_mem[307]  = 24'h0C0D0E;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rgb",   rgb, 24'h000000);
    check("rst_addr",  24'(spr_addr), 24'h0);
    check("rst_tick",  24'(frame_tick), 24'h0);
    check("rst_ready", 24'(pos_ready), 24'h0);
    rst = 1'b0;
    step(1, 1, 24'h000000);
    check("ready_after_rst", 24'(pos_ready), 24'h1);

    // Background pass-through with exact 2-cycle latency, blanking
    step(48, 33, 24'h123456);
    step(49, 33, 24'h654321);
    check("bg_first", rgb, 24'h123456);
    step(1, 1, 24'h000000);
    check("bg_second", rgb, 24'h654321);
    pix(10, 33, 24'h123456);
    check("blank_black", rgb, 24'h000000);

    // Position handshake and commit
    spr_en = 1'b1;
    offer(100, 50);
    check("ready_low", 24'(pos_ready), 24'h0);
    vis(100, 50, 24'h0A0B0C);
    check("no_sprite_before_commit", rgb, 24'h0A0B0C);
    step(0, 0, 24'h000000);
    check("tick_high", 24'(frame_tick), 24'h1);
    check("ready_after_commit", 24'(pos_ready), 24'h1);
    step(1, 1, 24'h000000);
    check("tick_low", 24'(frame_tick), 24'h0);

    vis(100, 50, 24'h111111);
    check("addr_tl", 24'(spr_addr), 24'd0);
    check("rgb_tl", rgb, 24'hAABBCC);
    vis(110, 51, 24'h111111);
    check("addr_mid", 24'(spr_addr), 24'd42);
    vis(131, 81, 24'h111111);
    check("addr_br", 24'(spr_addr), 24'd1023);
    check("rgb_br", rgb, 24'h010203);
    vis(132, 81, 24'h222222);
    check("right_of_sprite", rgb, 24'h222222);
    check("addr_hold", 24'(spr_addr), 24'd1023);
    vis(99, 50, 24'h333333);
    check("left_of_sprite", rgb, 24'h333333);

    // Key colour transparency
    rom_mem[0] = 24'hFF00FF;
    vis(100, 50, 24'h444444);
    check("key_transparent", rgb, 24'h444444);
    rom_mem[0] = 24'hFF00FE;
    vis(100, 50, 24'h444444);
    check("near_key_opaque", rgb, 24'hFF00FE);
    rom_mem[0] = 24'hAABBCC;

    // Pending update held until commit; second offer held off
    offer(200, 200);
    check("ready_low_pending", 24'(pos_ready), 24'h0);
    pos_x = 10'd300; pos_y = 10'd300; pos_valid = 1'b1;
    vis(100, 50, 24'h555555);
    check("old_pos_draws", rgb, 24'hAABBCC);
    vis(200, 200, 24'h666666);
    check("new_pos_not_yet", rgb, 24'h666666);
    check("ready_held_low", 24'(pos_ready), 24'h0);
    step(0, 0, 24'h000000);
    check("ready_rise", 24'(pos_ready), 24'h1);
    step(1, 1, 24'h000000);
    pos_valid = 1'b0;
    check("second_accepted", 24'(pos_ready), 24'h0);
    vis(200, 200, 24'h777777);
    check("pos_200_draws", rgb, 24'hAABBCC);
    vis(100, 50, 24'h777777);
    check("pos_100_gone", rgb, 24'h777777);
    vis(300, 300, 24'h888888);
    check("pos_300_not_yet", rgb, 24'h888888);
    step(0, 0, 24'h000000);
    vis(300, 300, 24'h888888);
    check("pos_300_draws", rgb, 24'hAABBCC);

    // Clipping at the bottom-right corner
    offer(620, 470);
    step(0, 0, 24'h000000);
    vis(620, 470, 24'h999999);
    check("clip_tl_addr", 24'(spr_addr), 24'd0);
    check("clip_tl_rgb", rgb, 24'hAABBCC);
    vis(639, 479, 24'h999999);
    check("clip_br_addr", 24'(spr_addr), 24'd307);
    check("clip_br_rgb", rgb, 24'h0C0D0E);
    vis(640, 479, 24'h999999);
    check("past_right_black", rgb, 24'h000000);
    vis(11, 5, 24'h121212);
    check("no_wrap_x", rgb, 24'h121212);
    vis(5, 21, 24'h131313);
    check("no_wrap_y", rgb, 24'h131313);

    // Reset mid-line drops the pending update and flushes the pipeline
    offer(200, 10);
    step(668, 503, 24'hDDDDDD);
    rst = 1'b1;
    step(1, 1, 24'h000000);
    check("rst_flush_rgb", rgb, 24'h000000);
    check("rst_ready_low", 24'(pos_ready), 24'h0);
    rst = 1'b0;
    step(1, 1, 24'h000000);
    check("pending_dropped", 24'(pos_ready), 24'h1);
    check("rst_black_next", rgb, 24'h000000);
    vis(5, 5, 24'h141414);
    check("en_cleared", rgb, 24'h141414);
    spr_en = 1'b0;
    step(0, 0, 24'h000000);
    vis(5, 5, 24'h141414);
    check("en_off_after_commit", rgb, 24'h141414);
    spr_en = 1'b1;
    step(0, 0, 24'h000000);
    vis(200, 10, 24'h151515);
    check("dropped_pos_absent", rgb, 24'h151515);
    vis(5, 5, 24'h161616);
    check("pos_origin_addr", 24'(spr_addr), 24'd165);
    check("pos_origin_rgb", rgb, 24'hAABBCC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
